// File: rtl/fir_pkg.sv
// Shared types for the FIR capture path: FSM states, default sizes, signed sample type.
// No logic, no latency; no flow control.
package fir_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int CAP_DEPTH = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port DEPTH x N RAM; 1-cycle synchronous read-first read, only the read register resets.
// No backpressure: a write and a read are accepted every cycle.
module capture_ram #(
  parameter int N     = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Storage is never cleared so a capture survives reset for offload.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fir_capture_buffer.sv
// Captures DEPTH filtered samples after an optional signed level trigger; 1-cycle readback, no backpressure
// (samples after the window fills are dropped). CAPTURE_PEAK_EN adds signed min/max tracking.
module fir_capture_buffer
  import fir_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = CAP_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  data_in,
  input  logic          sample_valid,
  input  logic          start,
  input  logic          trig_en,
  input  logic [N-1:0]  trig_level,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [N-1:0]  peak_max,
  output logic [N-1:0]  peak_min
);

  cap_state_e          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic signed [N-1:0] level_q, level_d;
  logic                rd_valid_q;
  logic                we;
  logic                arm_clr;
  logic                last_wr;

  assign last_wr = (count_q == (AW+1)'(DEPTH-1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    level_d  = level_q;
    we       = 1'b0;
    arm_clr  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          arm_clr  = 1'b1;
          wr_ptr_d = '0;
          count_d  = '0;
          level_d  = $signed(trig_level);
          state_d  = trig_en ? ARMED : CAPTURE;
        end
      end
      // The trigger sample lands at address 0 because wr_ptr was cleared on start.
      ARMED: begin
        if (sample_valid && ($signed(data_in) >= level_q)) begin
          we      = 1'b1;
          state_d = last_wr ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          we      = 1'b1;
          state_d = last_wr ? DONE : CAPTURE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      level_q    <= level_d;
      rd_valid_q <= rd_en;
    end
  end

  capture_ram #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we && !reset),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef CAPTURE_PEAK_EN
  logic signed [N-1:0] pmax_q, pmin_q;

  // First stored sample of a capture seeds both extremes.
  always_ff @(posedge clk) begin
    if (reset || arm_clr) begin
      pmax_q <= '0;
      pmin_q <= '0;
    end else if (we) begin
      if ((count_q == '0) || ($signed(data_in) > pmax_q)) pmax_q <= $signed(data_in);
      if ((count_q == '0) || ($signed(data_in) < pmin_q)) pmin_q <= $signed(data_in);
    end
  end

  assign peak_max = pmax_q;
  assign peak_min = pmin_q;
`else
  assign peak_max = '0;
  assign peak_min = '0;
`endif

  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ARMED) || (state_q == CAPTURE);
  assign done     = (state_q == DONE);
  assign count    = count_q;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Bench for fir_capture_buffer: directed table and sequences plus random traffic, all checked
// every cycle against a window/queue model of the capture rules.
module tb_fir_capture_buffer;
  import fir_pkg::*;

  localparam int N     = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  sample_t       data_in;
  logic          sample_valid;
  logic          start;
  logic          trig_en;
  logic [N-1:0]  trig_level;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [N-1:0]  peak_max;
  logic [N-1:0]  peak_min;

  always #5 clk = ~clk;

  fir_capture_buffer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .sample_valid (sample_valid),
    .start        (start),
    .trig_en      (trig_en),
    .trig_level   (trig_level),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .done         (done),
    .count        (count),
    .peak_max     (peak_max),
    .peak_min     (peak_min)
  );

  // Reference model: the stored window is a queue, memory an array that outlives captures.
  sample_t m_mem [DEPTH];
  bit      m_known [DEPTH];
  sample_t m_win [$];
  bit      m_wait, m_cap, m_fin;
  sample_t m_level;
  sample_t e_rd;
  bit      e_rd_known;
  bit      e_rv;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_wait = 0; m_cap = 0; m_fin = 0;
      m_win.delete();
      e_rd = '0; e_rd_known = 1; e_rv = 0;
      return;
    end
    e_rv = rd_en;
    if (rd_en) begin
      e_rd       = m_mem[rd_addr];
      e_rd_known = m_known[rd_addr];
    end
    if (!(m_wait || m_cap) && start) begin
      m_win.delete();
      m_level = sample_t'(trig_level);
      m_wait  = trig_en;
      m_cap   = !trig_en;
      m_fin   = 0;
    end else if (sample_valid && (m_cap || (m_wait && data_in >= m_level))) begin
      m_mem[m_win.size()]   = data_in;
      m_known[m_win.size()] = 1;
      m_win.push_back(data_in);
      m_wait = 0;
      m_cap  = (m_win.size() < DEPTH);
      m_fin  = !m_cap;
    end
  endtask

  task automatic check_all();
    int emax, emin;
    emax = 0; emin = 0;
`ifdef CAPTURE_PEAK_EN
    foreach (m_win[k]) begin
      if (k == 0 || int'(m_win[k]) > emax) emax = int'(m_win[k]);
      if (k == 0 || int'(m_win[k]) < emin) emin = int'(m_win[k]);
    end
`endif
    chk("busy", int'(busy), int'(m_wait || m_cap));
    chk("done", int'(done), int'(m_fin));
    chk("count", int'(count), m_win.size());
    chk("rd_valid", int'(rd_valid), int'(e_rv));
    if (e_rd_known) chk("rd_data", int'($signed(rd_data)), int'(e_rd));
    chk("peak_max", int'($signed(peak_max)), emax);
    chk("peak_min", int'($signed(peak_min)), emin);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit st, input bit te, input int lvl, input bit v,
                       input int d, input bit re, input int ra);
    start        = st;
    trig_en      = te;
    trig_level   = N'(lvl);
    sample_valid = v;
    data_in      = N'(d);
    rd_en        = re;
    rd_addr      = AW'(ra);
    cyc();
  endtask

  typedef struct {
    bit st; bit te; int lvl; bit v; int d; bit re; int ra;
    bit x_busy; int x_count; bit x_rv; int x_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl = '{
      '{1, 1, 100, 0,   0, 0, 0, 1, 0, 0,   0},
      '{0, 0,   0, 1,  50, 0, 0, 1, 0, 0,   0},
      '{0, 0,   0, 1,  99, 0, 0, 1, 0, 0,   0},
      '{0, 0,   0, 1, 100, 0, 0, 1, 1, 0,   0},
      '{0, 0,   0, 1,   7, 0, 0, 1, 2, 0,   0},
      '{0, 0,   0, 0,   0, 1, 0, 1, 2, 1, 100},
      '{0, 0,   0, 0,   0, 1, 1, 1, 2, 1,   7},
      '{0, 0,   0, 0,   0, 1, 2, 1, 2, 1,   2},
      '{1, 0,   0, 0,   0, 0, 0, 1, 2, 0,   0}
    };
    foreach (m_known[k]) m_known[k] = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Immediate capture of 0..31 and full readback.
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("imm_busy", int'(busy), 1);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 1, i, 0, 0);
    chk("imm_done", int'(done), 1);
    chk("imm_count", int'(count), 32);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 1, i);
      chk("imm_rd", int'($signed(rd_data)), i);
    end

    // Level trigger at 100, including an old-contents read and an ignored start.
    foreach (tbl[r]) begin
      drive(tbl[r].st, tbl[r].te, tbl[r].lvl, tbl[r].v, tbl[r].d, tbl[r].re, tbl[r].ra);
      chk("tbl_busy", int'(busy), int'(tbl[r].x_busy));
      chk("tbl_count", int'(count), tbl[r].x_count);
      chk("tbl_rv", int'(rd_valid), int'(tbl[r].x_rv));
      if (tbl[r].re) chk("tbl_rd", int'($signed(rd_data)), tbl[r].x_rd);
    end

    // Overrun: 40 samples, start pulses while busy including on the final accepted sample.
    for (int i = 0; i < 40; i++)
      drive((i < 30) && ((i % 7) == 3 || i == 29), 0, 0, 1, 200 + i, 0, 0);
    chk("ovr_count", int'(count), 32);
    chk("ovr_done", int'(done), 1);
    drive(0, 0, 0, 0, 0, 1, 31);
    chk("ovr_last", int'($signed(rd_data)), 229);

    // Restart in DONE with a negative threshold and gapped samples.
    drive(1, 1, -5, 0, 0, 0, 0);
    chk("neg_count0", int'(count), 0);
    chk("neg_busy", int'(busy), 1);
    drive(0, 0, 0, 1, -10, 0, 0);
    drive(0, 0, 0, 0, -5, 0, 0);
    drive(0, 0, 0, 1, -6, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, -5, 0, 0);
    drive(0, 0, 0, 0, 9, 0, 0);
    drive(0, 0, 0, 1, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("neg_count", int'(count), 2);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("neg_rd0", int'($signed(rd_data)), -5);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("neg_rd1", int'($signed(rd_data)), 3);

    // Reset after 10 stored samples; memory must survive.
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 1000 + i, 0, 0);
    chk("mid_count", int'(count), 10);
    reset = 1'b1;
    drive(0, 0, 0, 1, 77, 1, 5);
    reset = 1'b0;
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_cnt0", int'(count), 0);
    chk("mid_rv", int'(rd_valid), 0);
    chk("mid_rd", int'(rd_data), 0);
    drive(0, 0, 0, 0, 0, 1, 3);
    chk("mid_rd3", int'($signed(rd_data)), 1001);

    // Peak tracking over 3, -7, 12, 0.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 3, 0, 0);
    drive(0, 0, 0, 1, -7, 0, 0);
    drive(0, 0, 0, 1, 12, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
`ifdef CAPTURE_PEAK_EN
    chk("pk_max", int'($signed(peak_max)), 12);
    chk("pk_min", int'($signed(peak_min)), -7);
`else
    chk("pk_max", int'($signed(peak_max)), 0);
    chk("pk_min", int'($signed(peak_min)), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 4000)) - 2000, $urandom_range(0, 99) < 70,
            int'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, DEPTH - 1)));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_capture_buffer.md
# fir_capture_buffer

Output-side companion to the FIR sample source: captures a window of filtered samples from `fir_filter` `data_out` into an internal RAM. Capture starts after an optional signed level trigger. The stored window can then be read back for checking or offload. It sits downstream of the filter in both the bench and the FPGA build, mirroring the ROM-driven stimulus path on the input side.

## Interface
Parameters:
- N, 16, sample width (two's complement)
- DEPTH, 32, capture window length in samples (power of two)
- AW, 5, address width, log2(DEPTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  N  filtered sample (from fir_filter data_out)
- sample_valid  in  1  data_in valid this cycle
- start  in  1  one-cycle pulse, arms a capture
- trig_en  in  1  sampled with start; 1 = wait for level trigger, 0 = capture immediately
- trig_level  in  N  signed trigger threshold, sampled with start
- rd_en  in  1  readback request
- rd_addr  in  AW  readback address
- rd_data  out  N  registered readback data
- rd_valid  out  1  rd_data valid (rd_en delayed one cycle)
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  level, high in DONE
- count  out  AW+1  samples stored in current capture, 0..DEPTH
- peak_max  out  N  signed maximum of captured samples
- peak_min  out  N  signed minimum of captured samples

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- From IDLE or DONE, on start:
  - Clear count and wr_ptr.
  - Latch trig_level.
  - Go to ARMED if trig_en=1, otherwise go to CAPTURE.
- start is ignored in ARMED and CAPTURE.
- ARMED: the first cycle with sample_valid=1 and $signed(data_in) >= $signed(latched level) is the trigger sample.
  - The trigger sample is stored at address 0.
  - State moves to CAPTURE, or straight to DONE if DEPTH=1.
- CAPTURE: each sample_valid=1 cycle writes data_in to mem[wr_ptr], then increments wr_ptr and count.
- After the DEPTH-th write, go to DONE. No wrap-around; extra samples are dropped.
- DONE holds until start or reset. Memory contents persist.
- Readback is allowed in any state. Reading a location not yet written in the current capture returns its old contents.
- Reset mid-capture returns to IDLE and clears all outputs. Memory contents are not cleared.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, count=0, peak_max=0, peak_min=0.
- A sample is written at the rising edge ending its valid cycle. count reflects it the next cycle.
- busy rises the cycle after start. done rises the cycle after the final sample is accepted.
- Readback latency is 1: rd_data/rd_valid are presented the cycle after rd_en.
- A same-cycle write and read at the same address returns the old data (read-first).
- start coincident with the final sample in CAPTURE: the sample is stored, the capture completes, and start is ignored.

## Configuration
- Macro `CAPTURE_PEAK_EN`.
- Defined:
  - peak_max and peak_min track the signed extremes of the samples stored in the current capture.
  - The first stored sample loads both.
  - Both are cleared on start and reset.
- Undefined: peak_max and peak_min are tied to 0 and no comparators are built. The ports exist in both builds.

## Structure
- A shared package `fir_pkg` holds:
  - the state enum (IDLE/ARMED/CAPTURE/DONE),
  - the default N and DEPTH constants,
  - the signed sample typedef.
- One sub-module, `capture_ram`: single-clock simple dual-port RAM with a synchronous read-first read port, DEPTH x N. The FSM, pointers and peak logic stay in the top module.

## Test plan
- Immediate capture:
  - Stimulus: start with trig_en=0, then 32 valid samples 0..31.
  - Response: done rises one cycle after the 32nd sample, count=32, readback of addresses 0..31 returns 0..31.
- Level trigger:
  - Stimulus: trig_level=100, start with trig_en=1, feed 50, 99, 100, 7 ...
  - Response: mem[0]=100, mem[1]=7, busy=1 from the cycle after start.
- Negative threshold and gaps:
  - Stimulus: trig_level=-5 (16'hFFFB), feed -10, -5 with sample_valid toggling.
  - Response: trigger on -5; invalid cycles are not stored and count increments only on valid cycles.
- Overrun and restart:
  - Stimulus: 40 samples after start; start pulses during CAPTURE; start again in DONE.
  - Response: only the first 32 are stored, start is ignored while busy, count returns to 0 on restart.
- Reset mid-capture:
  - Stimulus: reset after 10 samples.
  - Response: all outputs return to reset values next cycle; state is IDLE; a following readback of address 3 returns the sample stored before reset.
- `CAPTURE_PEAK_EN`:
  - Stimulus: capture 3, -7, 12, 0.
  - Response: peak_max=12, peak_min=-7; with the macro undefined, both stay 0.
